ppu_bg_line_fetch: RTL and testbench
====================================

// Module: ppu_bg_line_fetch
// PURPOSE
//  Parametrised background scanline fetch engine for the PPU; successor to the fixed 40-tile hsync loader.
//  On a start pulse, reads tile IDs from the tile buffer and one graphics row per tile from tile graphics.
//  Fills the back half of a ping-pong line buffer, with X/Y scroll and map wrap-around.
//  Serves per-pixel colour indices from the front half to the pixel compositor.
// PARAMETERS
//  TILES_PER_LINE 40  visible tiles per line; engine fetches N_FETCH = TILES_PER_LINE+1 (fine-X spill)
//  TILE_W         16  tile width in pixels; TILE_W*BPP must equal 32 (one graphics word per tile row)
//  TILE_H         16  tile height in rows
//  BPP            2   bits per pixel colour index
//  MAP_W          64  map width in tiles, power of two, multiple of 4
//  MAP_H          32  map height in tiles, power of two
//  RD_LAT         1   read latency of both RAMs, in cycles (>=1)
//  TB_AW          9   tile buffer address width, = log2(MAP_W*MAP_H/4)
//  TG_AW          11  tile graphics address width, = log2(128*TILE_H)
// PORTS
//  clk       in   1      single clock
//  reset_n   in   1      asynchronous, active-low reset
//  start     in   1      1-cycle pulse: fetch line line_y into back buffer
//  line_y    in   10     target screen line, sampled with start
//  scroll_x  in   10     background X scroll in pixels, sampled with start
//  scroll_y  in   10     background Y scroll in pixels, sampled with start
//  swap      in   1      1-cycle pulse: exchange front/back buffers
//  busy      out  1      high from cycle after accepted start until done
//  done      out  1      1-cycle pulse when last graphics word is stored
//  overrun   out  1      sticky: swap seen while busy
//  tb_rd     out  1      tile buffer read strobe
//  tb_addr   out  TB_AW  tile buffer word address
//  tb_rdata  in   32     four 8-bit entries; entry[6:0]=tile id, [7]=palette
//  tg_rd     out  1      tile graphics read strobe
//  tg_addr   out  TG_AW  tile graphics word address
//  tg_rdata  in   32     one tile row, pixel p at bits [p*BPP +: BPP]
//  pix_x     in   11     screen pixel 0..TILES_PER_LINE*TILE_W-1
//  pix_idx   out  BPP    colour index for pix_x, registered, 1-cycle latency
//  pix_pal   out  1      palette select for pix_x, same timing as pix_idx
// BEHAVIOUR
//  Reset (async assert, sync deassert): all outputs 0, FSM IDLE, front=0, buffers and overrun cleared.
//   A reset mid-fetch aborts with no done pulse.
//  FSM: IDLE -> ID_RD -> ID_WAIT -> GFX_RD -> GFX_WAIT -> (k<N_FETCH-1 ? ID_RD : DONE) -> IDLE.
//   start is accepted only in IDLE; start while busy is ignored.
//  Arithmetic at start: vy = (line_y + scroll_y) mod (MAP_H*TILE_H);
//   row = vy/TILE_H; fy = vy%TILE_H; cx0 = scroll_x/TILE_W; fine_x = scroll_x%TILE_W.
//  Tile k: col = (cx0+k) mod MAP_W; tb_addr = row*MAP_W/4 + col/4; entry = tb_rdata byte col%4.
//   Both row and col wrap; tb_addr never exceeds the map.
//  Timing per tile, cycle a relative to tile start:
//   a: tb_rd=1
//   a+RD_LAT: id/pal captured
//   a+RD_LAT+1: tg_rd=1, tg_addr = id*TILE_H + fy
//   a+2*RD_LAT+1: word and pal written to back slot k
//   Next tile starts at a+2*RD_LAT+2. Strobes are high exactly one cycle; addresses hold otherwise.
//  Latency: start sampled at cycle 0; first tb_rd at cycle 1; done at cycle N_FETCH*(2*RD_LAT+2)+1
//   (165 at defaults). busy falls the same cycle done rises.
//  swap: honoured only when !busy. It toggles front and moves the back buffer's fine_x to the front.
//   swap while busy is ignored and sets overrun.
//   swap and start in the same idle cycle: swap first, then the fetch fills the new back buffer.
//  Pixel path: p = pix_x + fine_x_front; slot = p/TILE_W; pix_idx = slot word bits [(p%TILE_W)*BPP +: BPP].
//   pix_pal = slot palette. Front reads never see back-buffer writes.
// STRUCTURE
//  ppu_pkg: fetch_state_t enum; tile_entry_t struct {pal, id[6:0]}; TILE_ROW_BITS=32.
//  Sub-module ppu_line_buffer: two banks of N_FETCH x (32+1) bits plus per-bank fine_x.
//   Provides a write port (bank, slot, data) and a registered pixel read port on the front bank.
//  Top: FSM, address arithmetic, latency counters, swap/overrun logic.
// TESTING
//  1) Defaults, scroll 0, line_y=0, map entry(c)=c -> tb_addr 0,0,0,0,1,...;
//     tg_addr=c*16; done at cycle 165; busy 164 cycles.
//  2) scroll_x=0x3F5 (cx0=63, fine_x=5) -> col sequence 63,0,1,...; after swap pix_x=0 reads slot0 pixel 5.
//  3) line_y=500, scroll_y=100 -> vy=88, row=5, fy=8; first tb_addr=80, tg_addr=id*16+8.
//  4) RD_LAT=3 build: strobe spacing 8 cycles per tile; done at cycle 41*8+1=329.
//  5) swap at cycle 50 of a fetch -> front unchanged, overrun=1; start during busy -> no restart.
//  6) reset_n low at cycle 70 of a fetch -> outputs 0 immediately, no done; a new start gives a full fetch.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types for the PPU background line fetch engine.
package ppu_pkg;

   localparam int TILE_ROW_BITS = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID_RD,
      ST_ID_WAIT,
      ST_GFX_RD,
      ST_GFX_WAIT,
      ST_DONE
   } fetch_state_t;

   typedef struct packed {
      logic       pal;
      logic [6:0] id;
   } tile_entry_t;

   // A tile-buffer word packs four map entries, lowest column in the low byte.
   function automatic tile_entry_t pick_entry(input logic [TILE_ROW_BITS-1:0] word,
                                              input logic [1:0] sel);
      return tile_entry_t'(word[8*sel +: 8]);
   endfunction

endpackage

// File: rtl/ppu_line_buffer.sv
// Ping-pong scanline store: the fetch engine writes the back bank while the
// compositor reads colour indices from the front bank.
module ppu_line_buffer
   import ppu_pkg::*;
#(
   parameter  int N_FETCH = 41,
   parameter  int TILE_W  = 16,
   parameter  int BPP     = 2,
   localparam int SW      = $clog2(N_FETCH),
   localparam int FW      = $clog2(TILE_W)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic                     wr_bank,
   input  logic [SW-1:0]            wr_slot,
   input  logic [TILE_ROW_BITS:0]   wr_data,
   input  logic                     fx_en,
   input  logic                     fx_bank,
   input  logic [FW-1:0]            fx_data,
   input  logic                     front,
   input  logic [10:0]              pix_x,
   output logic [BPP-1:0]           pix_idx,
   output logic                     pix_pal
);

   logic [N_FETCH-1:0][TILE_ROW_BITS:0] mem [2];
   logic [FW-1:0]                       fine_x [2];
   logic [TILE_ROW_BITS:0]              rd_word;
   logic [31:0]                         p, slot, sub;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem[0]    <= '0;
         mem[1]    <= '0;
         fine_x[0] <= '0;
         fine_x[1] <= '0;
      end else begin
         if (wr_en) mem[wr_bank][wr_slot] <= wr_data;
         if (fx_en) fine_x[fx_bank] <= fx_data;
      end
   end

   // Pixels past the last fetched slot read as transparent.
   always_comb begin
      p       = 32'(pix_x) + 32'(fine_x[front]);
      slot    = p / TILE_W;
      sub     = p % TILE_W;
      rd_word = '0;
      if (slot < N_FETCH) rd_word = mem[front][SW'(slot)];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_idx <= '0;
         pix_pal <= 1'b0;
      end else begin
         pix_idx <= rd_word[sub*BPP +: BPP];
         pix_pal <= rd_word[TILE_ROW_BITS];
      end
   end

endmodule

// File: rtl/ppu_bg_line_fetch.sv
// Background scanline fetch: walks the tile map for one line, pulls one graphics
// row per tile into the back line buffer, and serves pixels from the front buffer.
module ppu_bg_line_fetch
   import ppu_pkg::*;
#(
   parameter int TILES_PER_LINE = 40,
   parameter int TILE_W         = 16,
   parameter int TILE_H         = 16,
   parameter int BPP            = 2,
   parameter int MAP_W          = 64,
   parameter int MAP_H          = 32,
   parameter int RD_LAT         = 1,
   parameter int TB_AW          = 9,
   parameter int TG_AW          = 11
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [9:0]                line_y,
   input  logic [9:0]                scroll_x,
   input  logic [9:0]                scroll_y,
   input  logic                      swap,
   output logic                      busy,
   output logic                      done,
   output logic                      overrun,
   output logic                      tb_rd,
   output logic [TB_AW-1:0]          tb_addr,
   input  logic [TILE_ROW_BITS-1:0]  tb_rdata,
   output logic                      tg_rd,
   output logic [TG_AW-1:0]          tg_addr,
   input  logic [TILE_ROW_BITS-1:0]  tg_rdata,
   input  logic [10:0]               pix_x,
   output logic [BPP-1:0]            pix_idx,
   output logic                      pix_pal
);

   localparam int N_FETCH = TILES_PER_LINE + 1;
   localparam int KW      = $clog2(N_FETCH);
   localparam int CW      = $clog2(MAP_W);
   localparam int RW      = $clog2(MAP_H);
   localparam int YW      = $clog2(TILE_H);
   localparam int FW      = $clog2(TILE_W);
   localparam int LW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   fetch_state_t  state, state_n;
   logic [LW-1:0] lat_cnt;
   logic [KW-1:0] k;
   logic [CW-1:0] col_q, col_s, col_nx;
   logic [RW-1:0] row_q, row_s;
   logic [YW-1:0] fy_q, fy_s;
   logic [FW-1:0] fine_s;
   logic [31:0]   vy;
   logic          bank_q, bank_s, pal_q, front;
   logic          accept, swap_ok, lat_last, last_tile, wr_en;
   tile_entry_t   entry;

   // Scroll arithmetic on the start inputs; both map axes wrap.
   always_comb begin
      vy     = (32'(line_y) + 32'(scroll_y)) % (MAP_H * TILE_H);
      row_s  = RW'(vy / TILE_H);
      fy_s   = YW'(vy % TILE_H);
      col_s  = CW'((32'(scroll_x) / TILE_W) % MAP_W);
      fine_s = FW'(32'(scroll_x) % TILE_W);
      col_nx = (col_q == CW'(MAP_W - 1)) ? '0 : col_q + CW'(1);
   end

   assign busy      = state inside {ST_ID_RD, ST_ID_WAIT, ST_GFX_RD, ST_GFX_WAIT};
   assign done      = (state == ST_DONE);
   assign tb_rd     = (state == ST_ID_RD);
   assign tg_rd     = (state == ST_GFX_RD);
   assign accept    = (state == ST_IDLE) && start;
   assign swap_ok   = swap && !busy;
   // A same-cycle swap is applied first, so the fetch targets the post-swap back bank.
   assign bank_s    = swap_ok ? front : ~front;
   assign lat_last  = (lat_cnt == LW'(RD_LAT - 1));
   assign last_tile = (k == KW'(N_FETCH - 1));
   assign entry     = pick_entry(tb_rdata, col_q[1:0]);
   assign wr_en     = (state == ST_GFX_WAIT) && lat_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:     if (start) state_n = ST_ID_RD;
         ST_ID_RD:    state_n = ST_ID_WAIT;
         ST_ID_WAIT:  if (lat_last) state_n = ST_GFX_RD;
         ST_GFX_RD:   state_n = ST_GFX_WAIT;
         ST_GFX_WAIT: if (lat_last) state_n = last_tile ? ST_DONE : ST_ID_RD;
         ST_DONE:     state_n = ST_IDLE;
         default:     state_n = ST_IDLE;
      endcase
   end

   // Reset deassertion is expected to arrive already synchronised to clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lat_cnt <= '0;
         k       <= '0;
         col_q   <= '0;
         row_q   <= '0;
         fy_q    <= '0;
         bank_q  <= 1'b0;
         pal_q   <= 1'b0;
         front   <= 1'b0;
         overrun <= 1'b0;
         tb_addr <= '0;
         tg_addr <= '0;
      end else begin
         if (swap_ok)       front   <= ~front;
         if (swap && busy)  overrun <= 1'b1;
         case (state)
            ST_IDLE: if (start) begin
               row_q   <= row_s;
               fy_q    <= fy_s;
               col_q   <= col_s;
               k       <= '0;
               bank_q  <= bank_s;
               tb_addr <= TB_AW'(32'(row_s) * (MAP_W / 4) + 32'(col_s) / 4);
            end
            ST_ID_RD, ST_GFX_RD: lat_cnt <= '0;
            ST_ID_WAIT: begin
               lat_cnt <= lat_cnt + LW'(1);
               if (lat_last) begin
                  pal_q   <= entry.pal;
                  tg_addr <= TG_AW'(32'(entry.id) * TILE_H + 32'(fy_q));
               end
            end
            ST_GFX_WAIT: begin
               lat_cnt <= lat_cnt + LW'(1);
               if (lat_last && !last_tile) begin
                  k       <= k + KW'(1);
                  col_q   <= col_nx;
                  tb_addr <= TB_AW'(32'(row_q) * (MAP_W / 4) + 32'(col_nx) / 4);
               end
            end
            default: ;
         endcase
      end
   end

   ppu_line_buffer #(
      .N_FETCH (N_FETCH),
      .TILE_W  (TILE_W),
      .BPP     (BPP)
   ) u_line_buffer (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_bank (bank_q),
      .wr_slot (k),
      .wr_data ({pal_q, tg_rdata}),
      .fx_en   (accept),
      .fx_bank (bank_s),
      .fx_data (fine_s),
      .front   (front),
      .pix_x   (pix_x),
      .pix_idx (pix_idx),
      .pix_pal (pix_pal)
   );

endmodule

// File: tb/tb_ppu_bg_line_fetch.sv
// Directed bench for the background line fetch engine at default and RD_LAT=3 builds.
module tb_ppu_bg_line_fetch;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, start3 = 1'b0, swap = 1'b0;
   logic [9:0]  line_y = '0, scroll_x = '0, scroll_y = '0;
   logic [10:0] pix_x = '0;
   logic        busy, done, overrun, tb_rd, tg_rd, pix_pal;
   logic [8:0]  tb_addr;
   logic [10:0] tg_addr;
   logic [31:0] tb_rdata, tg_rdata;
   logic [1:0]  pix_idx;
   logic        busy3, done3, overrun3, tb_rd3, tg_rd3, pix_pal3;
   logic [8:0]  tb_addr3;
   logic [10:0] tg_addr3;
   logic [31:0] tb_rdata3, tg_rdata3;
   logic [1:0]  pix_idx3;
   int          nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   ppu_bg_line_fetch dut (
      .clk(clk), .reset_n(reset_n), .start(start), .line_y(line_y), .scroll_x(scroll_x),
      .scroll_y(scroll_y), .swap(swap), .busy(busy), .done(done), .overrun(overrun),
      .tb_rd(tb_rd), .tb_addr(tb_addr), .tb_rdata(tb_rdata), .tg_rd(tg_rd), .tg_addr(tg_addr),
      .tg_rdata(tg_rdata), .pix_x(pix_x), .pix_idx(pix_idx), .pix_pal(pix_pal));

   ppu_bg_line_fetch #(.RD_LAT(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .start(start3), .line_y(line_y), .scroll_x(scroll_x),
      .scroll_y(scroll_y), .swap(1'b0), .busy(busy3), .done(done3), .overrun(overrun3),
      .tb_rd(tb_rd3), .tb_addr(tb_addr3), .tb_rdata(tb_rdata3), .tg_rd(tg_rd3), .tg_addr(tg_addr3),
      .tg_rdata(tg_rdata3), .pix_x(pix_x), .pix_idx(pix_idx3), .pix_pal(pix_pal3));

   // Map entry for (row, col): id = (col + 3*row) % 128, palette = row parity.
   function automatic logic [31:0] tb_word(input logic [8:0] a);
      logic [31:0] w;
      int row, col;
      row = int'(a) / 16;
      for (int j = 0; j < 4; j++) begin
         col = (int'(a) % 16) * 4 + j;
         w[j*8 +: 8] = {1'(row % 2), 7'((col + 3 * row) % 128)};
      end
      return w;
   endfunction

   function automatic logic [31:0] gfx(input logic [10:0] a);
      return ({21'd0, a} * 32'h9E3779B1) ^ 32'h0F0F3C3C;
   endfunction

   function automatic void pix_model(input int x, ly, sx, sy,
                                     output logic [1:0] idx, output logic pal);
      int vy, row, fy, p, slot, col, id;
      logic [31:0] w;
      vy   = (ly + sy) % 512;
      row  = vy / 16;
      fy   = vy % 16;
      p    = x + sx % 16;
      slot = p / 16;
      col  = (sx / 16 + slot) % 64;
      id   = (col + 3 * row) % 128;
      w    = gfx(11'(id * 16 + fy));
      idx  = w[(p % 16) * 2 +: 2];
      pal  = 1'(row % 2);
   endfunction

   // RAM models: RD_LAT=1 for dut, RD_LAT=3 for dut3.
   logic [31:0] tbq, tgq;
   logic [31:0] tbq3 [3];
   logic [31:0] tgq3 [3];
   always @(posedge clk) begin
      if (tb_rd)  tbq <= tb_word(tb_addr);
      if (tg_rd)  tgq <= gfx(tg_addr);
      if (tb_rd3) tbq3[0] <= tb_word(tb_addr3);
      if (tg_rd3) tgq3[0] <= gfx(tg_addr3);
      tbq3[1] <= tbq3[0]; tbq3[2] <= tbq3[1];
      tgq3[1] <= tgq3[0]; tgq3[2] <= tgq3[1];
   end
   assign tb_rdata  = tbq;
   assign tg_rdata  = tgq;
   assign tb_rdata3 = tbq3[2];
   assign tg_rdata3 = tgq3[2];

   task automatic test_reset();
      reset_n = 1'b0; pix_x = '0;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({busy, done, overrun, tb_rd, tg_rd} !== 5'b0) begin
         nerr++; $display("FAIL reset_ctl: got %b want 00000", {busy, done, overrun, tb_rd, tg_rd});
      end
      nvec++;
      if (tb_addr !== 9'd0 || tg_addr !== 11'd0) begin
         nerr++; $display("FAIL reset_addr: got tb=%0d tg=%0d want 0 0", tb_addr, tg_addr);
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      nvec++;
      if ({pix_idx, pix_pal} !== 3'b0) begin
         nerr++; $display("FAIL reset_pix: got %b want 000", {pix_idx, pix_pal});
      end
      nvec++;
      if ({busy3, done3, tb_rd3, tg_rd3} !== 4'b0) begin
         nerr++; $display("FAIL reset_lat3: got %b want 0000", {busy3, done3, tb_rd3, tg_rd3});
      end
   endtask

   task automatic test_fetch_line(input int ly, input int sx, input int sy, input string name);
      int vy, row, fy, cx0, k, col, id;
      int xs [8] = '{0, 7, 10, 11, 16, 333, 624, 639};
      logic [3:0] ctl_exp;
      logic [1:0] ei;
      logic       ep;
      vy = (ly + sy) % 512; row = vy / 16; fy = vy % 16; cx0 = (sx / 16) % 64;
      line_y = 10'(ly); scroll_x = 10'(sx); scroll_y = 10'(sy); start = 1'b1;
      for (int cyc = 1; cyc <= 166; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         ctl_exp = {cyc <= 164, cyc == 165, cyc <= 161 && (cyc - 1) % 4 == 0,
                    cyc >= 3 && cyc <= 163 && (cyc - 3) % 4 == 0};
         nvec++;
         if ({busy, done, tb_rd, tg_rd} !== ctl_exp) begin
            nerr++; $display("FAIL %s_ctl cyc %0d: got %b want %b", name, cyc, {busy, done, tb_rd, tg_rd}, ctl_exp);
         end
         if (ctl_exp[1]) begin
            k = (cyc - 1) / 4; col = (cx0 + k) % 64;
            nvec++;
            if (tb_addr !== 9'(row * 16 + col / 4)) begin
               nerr++; $display("FAIL %s_tb_addr tile %0d: got %0d want %0d", name, k, tb_addr, row * 16 + col / 4);
            end
         end
         if (ctl_exp[0]) begin
            k = (cyc - 3) / 4; col = (cx0 + k) % 64; id = (col + 3 * row) % 128;
            nvec++;
            if (tg_addr !== 11'(id * 16 + fy)) begin
               nerr++; $display("FAIL %s_tg_addr tile %0d: got %0d want %0d", name, k, tg_addr, id * 16 + fy);
            end
         end
      end
      swap = 1'b1;
      @(posedge clk); #1;
      swap = 1'b0;
      for (int i = 0; i < 8; i++) begin
         pix_x = 11'(xs[i]);
         @(posedge clk); #1;
         pix_model(xs[i], ly, sx, sy, ei, ep);
         nvec++;
         if ({pix_idx, pix_pal} !== {ei, ep}) begin
            nerr++; $display("FAIL %s_pix x=%0d: got %b want %b", name, xs[i], {pix_idx, pix_pal}, {ei, ep});
         end
      end
   endtask

   task automatic test_rd_lat3();
      int k;
      logic [3:0] ctl_exp;
      line_y = '0; scroll_x = '0; scroll_y = '0; start3 = 1'b1;
      for (int cyc = 1; cyc <= 330; cyc++) begin
         @(posedge clk); #1;
         start3 = 1'b0;
         ctl_exp = {cyc <= 328, cyc == 329, cyc <= 321 && (cyc - 1) % 8 == 0,
                    cyc >= 5 && cyc <= 325 && (cyc - 5) % 8 == 0};
         nvec++;
         if ({busy3, done3, tb_rd3, tg_rd3} !== ctl_exp) begin
            nerr++; $display("FAIL lat3_ctl cyc %0d: got %b want %b", cyc, {busy3, done3, tb_rd3, tg_rd3}, ctl_exp);
         end
         if (ctl_exp[1]) begin
            k = (cyc - 1) / 8;
            nvec++;
            if (tb_addr3 !== 9'(k / 4)) begin
               nerr++; $display("FAIL lat3_tb_addr tile %0d: got %0d want %0d", k, tb_addr3, k / 4);
            end
         end
         if (ctl_exp[0]) begin
            k = (cyc - 5) / 8;
            nvec++;
            if (tg_addr3 !== 11'(k * 16)) begin
               nerr++; $display("FAIL lat3_tg_addr tile %0d: got %0d want %0d", k, tg_addr3, k * 16);
            end
         end
      end
   endtask

   task automatic test_overrun();
      int xa [2] = '{0, 333};
      int xb [3] = '{0, 13, 639};
      logic [1:0] ei;
      logic       ep;
      line_y = 10'd20; scroll_x = 10'd3; scroll_y = '0; start = 1'b1;
      for (int cyc = 1; cyc <= 166; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == 60);
         swap  = (cyc == 50);
         nvec++;
         if ({busy, done} !== {cyc <= 164, cyc == 165}) begin
            nerr++; $display("FAIL ovr_ctl cyc %0d: got %b want %b", cyc, {busy, done}, {cyc <= 164, cyc == 165});
         end
         if (cyc == 49 || cyc == 51 || cyc == 166) begin
            nvec++;
            if (overrun !== (cyc != 49)) begin
               nerr++; $display("FAIL ovr_flag cyc %0d: got %b want %b", cyc, overrun, cyc != 49);
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         pix_x = 11'(xa[i]);
         @(posedge clk); #1;
         pix_model(xa[i], 500, 0, 100, ei, ep);
         nvec++;
         if ({pix_idx, pix_pal} !== {ei, ep}) begin
            nerr++; $display("FAIL ovr_front_kept x=%0d: got %b want %b", xa[i], {pix_idx, pix_pal}, {ei, ep});
         end
      end
      swap = 1'b1;
      @(posedge clk); #1;
      swap = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pix_x = 11'(xb[i]);
         @(posedge clk); #1;
         pix_model(xb[i], 20, 3, 0, ei, ep);
         nvec++;
         if ({pix_idx, pix_pal} !== {ei, ep}) begin
            nerr++; $display("FAIL ovr_after_swap x=%0d: got %b want %b", xb[i], {pix_idx, pix_pal}, {ei, ep});
         end
      end
      nvec++;
      if (overrun !== 1'b1) begin
         nerr++; $display("FAIL ovr_sticky: got %b want 1", overrun);
      end
   endtask

   task automatic test_reset_mid();
      line_y = '0; scroll_x = '0; scroll_y = '0; start = 1'b1;
      for (int cyc = 1; cyc <= 70; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      nvec++;
      if ({busy, done, overrun, tb_rd, tg_rd, pix_idx, pix_pal} !== 8'b0) begin
         nerr++; $display("FAIL midrst_ctl: got %b want 00000000", {busy, done, overrun, tb_rd, tg_rd, pix_idx, pix_pal});
      end
      nvec++;
      if (tb_addr !== 9'd0 || tg_addr !== 11'd0) begin
         nerr++; $display("FAIL midrst_addr: got tb=%0d tg=%0d want 0 0", tb_addr, tg_addr);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         nvec++;
         if ({busy, done} !== 2'b0) begin
            nerr++; $display("FAIL midrst_nodone %0d: got %b want 00", i, {busy, done});
         end
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_fetch_line(40, 21, 7, "post_reset");
   endtask

   initial begin
      test_reset();
      test_fetch_line(0, 0, 0, "basic");
      test_fetch_line(0, 1013, 0, "scroll_x");
      test_fetch_line(500, 0, 100, "scroll_y");
      test_rd_lat3();
      test_overrun();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
